boot_sequencer: RTL

//  Sequences SoC boot around the bootloader ROM. Holds the core in reset for a fixed

---
 rtl/boot_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the core in reset, selects the ROM program, then
// watches the imem bus and ROM flags to declare boot done or failed.
module boot_sequencer #(
    parameter logic [31:0] BOOTLOADER_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] BOOTLOADER_BYTES     = 32'd188,
    parameter int unsigned RESET_HOLD_CYCLES    = 16,
    parameter int unsigned BOOT_TIMEOUT_CYCLES  = 20000,
    parameter int unsigned CNT_WIDTH            = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 boot_mode_i,
    input  logic                 soft_reboot_i,
    input  logic                 imem_req_i,
    input  logic                 imem_gnt_i,
    input  logic [31:0]          imem_addr_i,
    input  logic                 illegal_access_i,
    input  logic                 illegal_write_i,
    output logic                 core_rst_no,
    output logic                 core_fetch_en_o,
    output logic                 copy_flash_o,
    output logic                 boot_done_o,
    output logic                 boot_error_o,
    output logic [1:0]           err_code_o,
    output logic [CNT_WIDTH-1:0] boot_cycles_o
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN_BOOT,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ACCESS  = 2'b01;
    localparam logic [1:0] ERR_WRITE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
    localparam logic [31:0]          BOOT_LAST = 32'(BOOT_TIMEOUT_CYCLES - 1);

    state_e               state;
    logic [CNT_WIDTH-1:0] hold_cnt;
    logic [31:0]          addr_off;
    logic                 exit_fetch;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 timeout;
    logic                 err_hit;
    logic [1:0]           err_sel;

    // Modulo subtraction makes addresses below the base land outside the window.
    assign addr_off   = imem_addr_i - BOOTLOADER_BASE_ADDR;
    assign exit_fetch = imem_req_i & imem_gnt_i & (addr_off >= BOOTLOADER_BYTES);
    assign cnt_nxt    = (&boot_cycles_o) ? boot_cycles_o : boot_cycles_o + CNT_ONE;
    assign timeout    = (32'(cnt_nxt) >= BOOT_LAST);

    always_comb begin
        err_hit = 1'b0;
        err_sel = ERR_NONE;
        if (illegal_write_i) begin
            err_hit = 1'b1;
            err_sel = ERR_WRITE;
        end else if (illegal_access_i) begin
            err_hit = 1'b1;
            err_sel = ERR_ACCESS;
        end else if (!exit_fetch && timeout) begin
            err_hit = 1'b1;
            err_sel = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_HOLD;
            hold_cnt        <= '0;
            core_rst_no     <= 1'b0;
            core_fetch_en_o <= 1'b0;
            copy_flash_o    <= 1'b0;
            boot_done_o     <= 1'b0;
            boot_error_o    <= 1'b0;
            err_code_o      <= ERR_NONE;
            boot_cycles_o   <= '0;
        end else if (soft_reboot_i) begin
            state           <= S_HOLD;
            hold_cnt        <= '0;
            core_rst_no     <= 1'b0;
            core_fetch_en_o <= 1'b0;
            boot_done_o     <= 1'b0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    core_rst_no     <= 1'b0;
                    core_fetch_en_o <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state           <= S_RUN_BOOT;
                        hold_cnt        <= '0;
                        copy_flash_o    <= boot_mode_i;
                        err_code_o      <= ERR_NONE;
                        boot_cycles_o   <= '0;
                        boot_error_o    <= 1'b0;
                        core_rst_no     <= 1'b1;
                        core_fetch_en_o <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                S_RUN_BOOT: begin
                    boot_cycles_o <= cnt_nxt;
                    if (err_hit) begin
                        state           <= S_ERROR;
                        err_code_o      <= err_sel;
                        boot_error_o    <= 1'b1;
                        core_rst_no     <= 1'b0;
                        core_fetch_en_o <= 1'b0;
                    end else if (exit_fetch) begin
                        state       <= S_DONE;
                        boot_done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule
